// File: rtl/uart_pkg.sv
// Shared definitions for the UART TX arbiter: FSM encoding, frame geometry
// and the end-of-bit helper used by the serializer.
package uart_pkg;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      SYNC  = 3'd1,
      START = 3'd2,
      DATA  = 3'd3,
      STOP  = 3'd4
   } uart_state_e;

   localparam int OVERSAMPLE_DEF  = 16;
   localparam int FRAME_DATA_BITS = 8;

   // True when the 4-bit tick counter sits on the last tick of a bit period.
   function automatic logic is_last_tick(input logic [3:0] cnt, input int os);
      return (cnt == 4'(os - 1));
   endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick over NREQ request lines: combinational one-hot grant,
// registered pointer that moves just past the winner when the grant is taken.
module rr_arbiter #(
   parameter int NREQ = 3
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [NREQ-1:0] i_req,
   input  logic            i_en,
   output logic [NREQ-1:0] o_grant,
   output logic            o_valid
);

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [PW-1:0]   r_ptr;
   logic [PW-1:0]   w_ptr_nxt;
   logic [NREQ-1:0] w_grant;
   logic            w_found;
   int              w_idx;

   // Search from the pointer upward, wrapping modulo NREQ; first set line wins.
   always_comb begin
      w_grant   = '0;
      w_found   = 1'b0;
      w_ptr_nxt = r_ptr;
      w_idx     = 0;
      for (int k = 0; k < NREQ; k++) begin
         w_idx = (int'(r_ptr) + k) % NREQ;
         if (!w_found && i_req[w_idx]) begin
            w_found        = 1'b1;
            w_grant[w_idx] = 1'b1;
            w_ptr_nxt      = PW'((w_idx + 1) % NREQ);
         end else begin
            w_found = w_found;
         end
      end
   end

   // Pointer register: advances only when the grant is actually consumed.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ptr <= '0;
      end else if (i_en && w_found) begin
         r_ptr <= w_ptr_nxt;
      end else begin
         r_ptr <= r_ptr;
      end
   end

   assign o_grant = w_grant;
   assign o_valid = w_found;

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one serial TX line between NREQ byte producers; each grant sends one
// 8-data-bit frame with STOP_BITS stop bits, bit time = OVERSAMPLE uart_clk rises.
module uart_tx_arbiter
   import uart_pkg::*;
#(
   parameter int NREQ       = 3,
   parameter int STOP_BITS  = 1,
   parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              uart_clk,
   input  logic [NREQ-1:0]   req,
   input  logic [8*NREQ-1:0] data,
   output logic [NREQ-1:0]   ack,
   output logic              tx,
   output logic              busy
);

   localparam logic [2:0] LAST_DATA_BIT = 3'(FRAME_DATA_BITS - 1);
   localparam logic       LAST_STOP     = 1'(STOP_BITS - 1);

   uart_state_e     r_state, w_state_nxt;
   logic            r_uclk_prev;
   logic [3:0]      r_tick_cnt, w_tick_cnt_nxt;
   logic [2:0]      r_bit_cnt, w_bit_cnt_nxt;
   logic            r_stop_cnt, w_stop_cnt_nxt;
   logic [7:0]      r_shift, w_shift_nxt;
   logic            r_tx, w_tx_nxt;
   logic            r_busy, w_busy_nxt;
   logic [NREQ-1:0] r_ack, w_ack_nxt;
   logic [NREQ-1:0] w_grant;
   logic            w_valid;
   logic            w_tick;
   logic            w_bit_end;
   logic [7:0]      w_sel_byte;
   logic [3:0]      w_tick_step;

   rr_arbiter #(.NREQ(NREQ)) u_arb (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_req   (req),
      .i_en    (r_state == IDLE),
      .o_grant (w_grant),
      .o_valid (w_valid)
   );

   // Previous uart_clk level resets high so release never fakes a rising edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_uclk_prev <= 1'b1;
      end else begin
         r_uclk_prev <= uart_clk;
      end
   end

   assign w_tick      = uart_clk & ~r_uclk_prev;
   assign w_bit_end   = w_tick & is_last_tick(r_tick_cnt, OVERSAMPLE);
   assign w_tick_step = w_bit_end ? 4'd0 : (r_tick_cnt + 4'd1);

   // Byte of the granted requester (grant is one-hot or zero).
   always_comb begin
      w_sel_byte = 8'h00;
      for (int i = 0; i < NREQ; i++) begin
         if (w_grant[i]) begin
            w_sel_byte = w_sel_byte | data[8*i +: 8];
         end else begin
            w_sel_byte = w_sel_byte;
         end
      end
   end

   // Next-state and datapath decode for the serializer.
   always_comb begin
      w_state_nxt    = r_state;
      w_tick_cnt_nxt = r_tick_cnt;
      w_bit_cnt_nxt  = r_bit_cnt;
      w_stop_cnt_nxt = r_stop_cnt;
      w_shift_nxt    = r_shift;
      w_tx_nxt       = r_tx;
      w_busy_nxt     = r_busy;
      w_ack_nxt      = '0;
      case (r_state)
         IDLE: begin
            if (w_valid) begin
               w_ack_nxt   = w_grant;
               w_shift_nxt = w_sel_byte;
               w_busy_nxt  = 1'b1;
               w_state_nxt = SYNC;
            end else begin
               w_state_nxt = IDLE;
            end
         end
         SYNC: begin
            if (w_tick) begin
               w_tx_nxt       = 1'b0;
               w_tick_cnt_nxt = 4'd0;
               w_state_nxt    = START;
            end else begin
               w_state_nxt = SYNC;
            end
         end
         START: begin
            if (w_tick) begin
               w_tick_cnt_nxt = w_tick_step;
            end else begin
               w_tick_cnt_nxt = r_tick_cnt;
            end
            if (w_bit_end) begin
               w_tx_nxt      = r_shift[0];
               w_shift_nxt   = {1'b0, r_shift[7:1]};
               w_bit_cnt_nxt = 3'd0;
               w_state_nxt   = DATA;
            end else begin
               w_state_nxt = START;
            end
         end
         DATA: begin
            if (w_tick) begin
               w_tick_cnt_nxt = w_tick_step;
            end else begin
               w_tick_cnt_nxt = r_tick_cnt;
            end
            if (w_bit_end && (r_bit_cnt != LAST_DATA_BIT)) begin
               w_tx_nxt      = r_shift[0];
               w_shift_nxt   = {1'b0, r_shift[7:1]};
               w_bit_cnt_nxt = r_bit_cnt + 3'd1;
            end else if (w_bit_end) begin
               w_tx_nxt       = 1'b1;
               w_stop_cnt_nxt = 1'b0;
               w_state_nxt    = STOP;
            end else begin
               w_state_nxt = DATA;
            end
         end
         STOP: begin
            if (w_tick) begin
               w_tick_cnt_nxt = w_tick_step;
            end else begin
               w_tick_cnt_nxt = r_tick_cnt;
            end
            if (w_bit_end && (r_stop_cnt == LAST_STOP)) begin
               w_busy_nxt  = 1'b0;
               w_state_nxt = IDLE;
            end else if (w_bit_end) begin
               w_stop_cnt_nxt = r_stop_cnt + 1'b1;
            end else begin
               w_state_nxt = STOP;
            end
         end
         default: begin
            w_tx_nxt    = 1'b1;
            w_busy_nxt  = 1'b0;
            w_state_nxt = IDLE;
         end
      endcase
   end

   // All serializer state; reset forces the line idle at once, abandoning any frame.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_tick_cnt <= 4'd0;
         r_bit_cnt  <= 3'd0;
         r_stop_cnt <= 1'b0;
         r_shift    <= 8'h00;
         r_tx       <= 1'b1;
         r_busy     <= 1'b0;
         r_ack      <= '0;
      end else begin
         r_state    <= w_state_nxt;
         r_tick_cnt <= w_tick_cnt_nxt;
         r_bit_cnt  <= w_bit_cnt_nxt;
         r_stop_cnt <= w_stop_cnt_nxt;
         r_shift    <= w_shift_nxt;
         r_tx       <= w_tx_nxt;
         r_busy     <= w_busy_nxt;
         r_ack      <= w_ack_nxt;
      end
   end

   assign ack  = r_ack;
   assign tx   = r_tx;
   assign busy = r_busy;

endmodule
